// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory bridge: FSM states,
// RV32I load/store funct3 encodings and the misalignment predicate.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } dmemState_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access size comes from funct3[1:0]: 00 byte, 01 half, 1x word.
  function automatic logic isMisaligned(input logic [2:0] funct3, input logic [1:0] addrLo);
    if (funct3[1])
      return addrLo != 2'b00;
    else if (funct3[0])
      return addrLo[0];
    else
      return 1'b0;
  endfunction

endpackage

// File: rtl/dmem_lane.sv
// Combinational byte-lane steering: store replication/strobes on the request
// side, byte/half extraction with sign/zero extension on the response side.
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [2:0]  stFunct3,
  input  logic [1:0]  stAddrLo,
  input  logic [31:0] stData,
  output logic [31:0] laneWdata,
  output logic [3:0]  laneWstrb,
  input  logic [2:0]  ldFunct3,
  input  logic [1:0]  ldAddrLo,
  input  logic [31:0] ldWord,
  output logic [31:0] ldResult
);

  logic [7:0]  ldBytes [4];
  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  for (genvar gi = 0; gi < 4; gi++) begin : gByte
    assign ldBytes[gi] = ldWord[8*gi +: 8];
  end

  assign byteSel = ldBytes[ldAddrLo];
  assign halfSel = ldAddrLo[1] ? ldWord[31:16] : ldWord[15:0];

  always_comb begin
    laneWdata = stData;
    laneWstrb = 4'b1111;
    case (stFunct3[1:0])
      2'b00: begin
        laneWdata = {4{stData[7:0]}};
        laneWstrb = 4'b0001 << stAddrLo;
      end
      2'b01: begin
        laneWdata = {2{stData[15:0]}};
        laneWstrb = 4'b0011 << {stAddrLo[1], 1'b0};
      end
      default: ;
    endcase
  end

  // Reserved encodings 011/110/111 fall through to a full word.
  always_comb begin
    ldResult = ldWord;
    case (ldFunct3)
      F3_B:    ldResult = {{24{byteSel[7]}}, byteSel};
      F3_H:    ldResult = {{16{halfSel[15]}}, halfSel};
      F3_BU:   ldResult = {24'h0, byteSel};
      F3_HU:   ldResult = {16'h0, halfSel};
      default: ldResult = ldWord;
    endcase
  end

endmodule

// File: rtl/dmem_bridge.sv
// CPU load/store to valid/ready word-bus bridge with a four-state handshake FSM.
// Optional DMEM_BRIDGE_MISALIGN_TRAP_EN turns misaligned half/word accesses into an error pulse.
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [2:0]        cpu_funct3,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  output logic              cpu_err,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_we,
  output logic [3:0]        bus_wstrb,
  output logic [31:0]       bus_wdata,
  input  logic              bus_rsp_valid,
  input  logic [31:0]       bus_rdata
);

  dmemState_t        stateReg, stateNext;
  logic [ADDR_W-1:0] addrReg;
  logic              weReg;
  logic [2:0]        funct3Reg;
  logic [31:0]       wdataReg;
  logic [3:0]        wstrbReg;
  logic [31:0]       rdataReg;
  logic [31:0]       laneWdata;
  logic [3:0]        laneWstrb;
  logic [31:0]       loadResult;
  logic              trapNow;

  dmem_lane uLane (
    .stFunct3  (cpu_funct3),
    .stAddrLo  (cpu_addr[1:0]),
    .stData    (cpu_wdata),
    .laneWdata (laneWdata),
    .laneWstrb (laneWstrb),
    .ldFunct3  (funct3Reg),
    .ldAddrLo  (addrReg[1:0]),
    .ldWord    (bus_rdata),
    .ldResult  (loadResult)
  );

`ifdef DMEM_BRIDGE_MISALIGN_TRAP_EN
  logic trapReg;

  assign trapNow = isMisaligned(cpu_funct3, cpu_addr[1:0]);
  assign cpu_err = (stateReg == DONE) && trapReg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      trapReg <= 1'b0;
    else if (stateReg == IDLE && cpu_req)
      trapReg <= trapNow;
  end
`else
  assign trapNow = 1'b0;
  assign cpu_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg  <= IDLE;
      addrReg   <= '0;
      weReg     <= 1'b0;
      funct3Reg <= 3'b000;
      wdataReg  <= 32'h0;
      wstrbReg  <= 4'h0;
      rdataReg  <= 32'h0;
    end else begin
      stateReg <= stateNext;
      if (stateReg == IDLE && cpu_req) begin
        addrReg   <= cpu_addr;
        weReg     <= cpu_we;
        funct3Reg <= cpu_funct3;
        wdataReg  <= laneWdata;
        wstrbReg  <= cpu_we ? laneWstrb : 4'h0;
      end
      // Stores complete through the same path but never touch the load result.
      if (stateReg == WAIT && bus_rsp_valid && !weReg)
        rdataReg <= loadResult;
    end
  end

  always_comb begin
    stateNext     = stateReg;
    cpu_stall     = 1'b0;
    bus_req_valid = 1'b0;
    case (stateReg)
      IDLE: begin
        cpu_stall = cpu_req;
        if (cpu_req)
          stateNext = trapNow ? DONE : REQ;
      end
      REQ: begin
        cpu_stall     = 1'b1;
        bus_req_valid = 1'b1;
        if (bus_req_ready)
          stateNext = WAIT;
      end
      WAIT: begin
        cpu_stall = 1'b1;
        if (bus_rsp_valid)
          stateNext = DONE;
      end
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign cpu_rdata = rdataReg;
  assign bus_addr  = {addrReg[ADDR_W-1:2], 2'b00};
  assign bus_we    = weReg;
  assign bus_wstrb = wstrbReg;
  assign bus_wdata = wdataReg;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed plus randomized checks of dmem_bridge against an arithmetic
// reference model of lane steering, extension, latency and reset behaviour.
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [2:0]  cpu_funct3;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        cpu_err;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_rsp_valid;
  logic [31:0] bus_rdata;

  int passCnt = 0;
  int checkCnt = 0;
  logic [31:0] expRdata = 32'h0;

  always #5 clk = ~clk;

  dmem_bridge #(.ADDR_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_req       (cpu_req),
    .cpu_we        (cpu_we),
    .cpu_funct3    (cpu_funct3),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_rdata     (cpu_rdata),
    .cpu_stall     (cpu_stall),
    .cpu_err       (cpu_err),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_addr      (bus_addr),
    .bus_we        (bus_we),
    .bus_wstrb     (bus_wstrb),
    .bus_wdata     (bus_wdata),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rdata     (bus_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic int sizeOf(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] loadModel(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] word);
    logic [31:0] b;
    logic [31:0] h;
    b = (word >> (8 * (addr % 4))) & 32'hFF;
    h = (word >> (8 * (addr & 32'd2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b - 32'd256 : b;
      3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return word;
    endcase
  endfunction

  task automatic checkBus(input string tag, input logic [31:0] expAddr, input logic we,
                          input logic [3:0] expStrb, input logic [31:0] expWdata);
    check({tag, ".valid"}, bus_req_valid, 1'b1);
    check({tag, ".stall"}, cpu_stall, 1'b1);
    check({tag, ".addr"}, bus_addr, expAddr);
    check({tag, ".we"}, bus_we, we);
    check({tag, ".wstrb"}, bus_wstrb, expStrb);
    if (we) check({tag, ".wdata"}, bus_wdata, expWdata);
  endtask

  // Called just after a rising edge with the bridge idle; leaves it idle.
  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] word,
                     input int readyDelay, input int rspDelay);
    logic [31:0] expWdata;
    logic [3:0]  expStrb;
    logic [31:0] expAddr;
    bit          trap;
    int          sz;
    sz = sizeOf(f3);
    expAddr = addr & ~32'd3;
    if (sz == 1) begin
      expWdata = (wd & 32'hFF) * 32'h01010101;
      expStrb  = 4'(1 << (addr % 4));
    end else if (sz == 2) begin
      expWdata = (wd & 32'hFFFF) * 32'h00010001;
      expStrb  = 4'(3 << (addr & 32'd2));
    end else begin
      expWdata = wd;
      expStrb  = 4'hF;
    end
    if (!we) expStrb = 4'h0;
`ifdef DMEM_BRIDGE_MISALIGN_TRAP_EN
    trap = (addr % sz) != 0;
`else
    trap = 1'b0;
`endif
    $display("txn we=%0d f3=%0d addr=%h wdata=%h word=%h rdy=%0d rsp=%0d trap=%0d",
             we, f3, addr, wd, word, readyDelay, rspDelay, trap);

    cpu_req = 1'b1; cpu_we = we; cpu_funct3 = f3; cpu_addr = addr; cpu_wdata = wd;
    #1;
    check("idle.stall", cpu_stall, 1'b1);
    check("idle.valid", bus_req_valid, 1'b0);
    @(posedge clk); #1;
    // The request must already be captured: scramble what the CPU presents.
    cpu_addr = $urandom; cpu_wdata = $urandom;
    #1;
    if (trap) begin
      check("trap.err", cpu_err, 1'b1);
      check("trap.valid", bus_req_valid, 1'b0);
      check("trap.stall", cpu_stall, 1'b0);
      check("trap.rdata", cpu_rdata, expRdata);
      cpu_req = 1'b0;
      @(posedge clk); #1;
      check("trap.errPulse", cpu_err, 1'b0);
      check("trap.validAfter", bus_req_valid, 1'b0);
      return;
    end
    for (int i = 0; i < readyDelay; i++) begin
      bus_req_ready = 1'b0;
      bus_rsp_valid = 1'($urandom);
      bus_rdata = $urandom;
      #1;
      checkBus("req.hold", expAddr, we, expStrb, expWdata);
      @(posedge clk); #1;
    end
    bus_req_ready = 1'b1;
    bus_rsp_valid = 1'($urandom);
    bus_rdata = $urandom;
    #1;
    checkBus("req.accept", expAddr, we, expStrb, expWdata);
    @(posedge clk); #1;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    for (int i = 0; i < rspDelay; i++) begin
      #1;
      check("wait.valid", bus_req_valid, 1'b0);
      check("wait.stall", cpu_stall, 1'b1);
      @(posedge clk); #1;
    end
    bus_rsp_valid = 1'b1;
    bus_rdata = word;
    #1;
    check("wait.rspStall", cpu_stall, 1'b1);
    @(posedge clk); #1;
    bus_rsp_valid = 1'b0;
    bus_rdata = $urandom;
    if (!we) expRdata = loadModel(f3, addr, word);
    #1;
    check("done.stall", cpu_stall, 1'b0);
    check("done.rdata", cpu_rdata, expRdata);
    check("done.err", cpu_err, 1'b0);
    check("done.valid", bus_req_valid, 1'b0);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    check("idle2.stall", cpu_stall, 1'b0);
    check("idle2.rdata", cpu_rdata, expRdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_funct3 = 3'd0; cpu_addr = 32'h0;
    cpu_wdata = 32'h0; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = 32'h0;
    #1;
    check("rst.valid", bus_req_valid, 1'b0);
    check("rst.stall", cpu_stall, 1'b0);
    check("rst.rdata", cpu_rdata, 32'h0);
    check("rst.err", cpu_err, 1'b0);
    check("rst.wstrb", bus_wstrb, 4'h0);
    check("rst.addr", bus_addr, 32'h0);
    cpu_req = 1'b1;
    #1;
    check("rst.stallFollowsReq", cpu_stall, 1'b1);
    cpu_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Store word, zero-wait bus
    txn(1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 0, 0);
    // Signed / unsigned byte loads from the top lane
    txn(1'b0, 3'b000, 32'h203, 32'h0, 32'h80000000, 0, 0);
    check("lb.literal", cpu_rdata, 32'hFFFFFF80);
    txn(1'b0, 3'b100, 32'h203, 32'h0, 32'h80000000, 1, 1);
    check("lbu.literal", cpu_rdata, 32'h00000080);
    // Store half into upper lanes with slow ready
    txn(1'b1, 3'b001, 32'h2, 32'h1234, 32'h0, 4, 0);
    check("sh.rdataKept", cpu_rdata, 32'h00000080);

    // Reset while waiting for the response, stale response afterwards
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_funct3 = 3'b010; cpu_addr = 32'h300;
    @(posedge clk); #1;
    bus_req_ready = 1'b1;
    @(posedge clk); #1;
    bus_req_ready = 1'b0;
    #1;
    check("abort.waitStall", cpu_stall, 1'b1);
    reset = 1'b1; cpu_req = 1'b0;
    #1;
    expRdata = 32'h0;
    check("abort.stall", cpu_stall, 1'b0);
    check("abort.rdata", cpu_rdata, expRdata);
    check("abort.valid", bus_req_valid, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    bus_rsp_valid = 1'b1; bus_rdata = 32'h55AA1234;
    #1;
    check("stale.stall", cpu_stall, 1'b0);
    @(posedge clk); #1;
    bus_rsp_valid = 1'b0;
    #1;
    check("stale.rdata", cpu_rdata, expRdata);
    check("stale.stall2", cpu_stall, 1'b0);
    check("stale.valid", bus_req_valid, 1'b0);
    @(posedge clk); #1;
    check("stale.rdata2", cpu_rdata, expRdata);

    // Misaligned word load: trap with the option, plain word load without
    txn(1'b0, 3'b010, 32'h101, 32'h0, 32'hCAFEF00D, 0, 0);

    for (int n = 0; n < 40; n++) begin
      logic        we;
      logic [2:0]  f3;
      we = 1'($urandom);
      f3 = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      txn(we, f3, $urandom & 32'hFFFF, $urandom, $urandom,
          $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
